// File: rtl/pcpi_initiator_if.sv
// Bundle of the command, PCPI request and response handshakes around pcpi_initiator.
// master: the initiator itself; slave: whatever feeds commands and answers PCPI.
interface pcpi_initiator_if #(
    parameter int unsigned CYC_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_insn;
    logic [31:0]      cmd_rs1;
    logic [31:0]      cmd_rs2;

    logic             pcpi_valid;
    logic [31:0]      pcpi_insn;
    logic [31:0]      pcpi_rs1;
    logic [31:0]      pcpi_rs2;
    logic             pcpi_wr;
    logic [31:0]      pcpi_rd;
    logic             pcpi_wait;
    logic             pcpi_ready;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_rd;
    logic             rsp_wr;
    logic             rsp_err;
    logic [CYC_W-1:0] rsp_cycles;

    modport master (
        input  cmd_valid, cmd_insn, cmd_rs1, cmd_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        input  rsp_ready,
        output cmd_ready,
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output rsp_valid, rsp_rd, rsp_wr, rsp_err, rsp_cycles
    );

    modport slave (
        output cmd_valid, cmd_insn, cmd_rs1, cmd_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        output rsp_ready,
        input  cmd_ready,
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  rsp_valid, rsp_rd, rsp_wr, rsp_err, rsp_cycles
    );
endinterface

// File: rtl/pcpi_initiator.sv
// Core-side PCPI initiator: issues one instruction, waits for the coprocessor, returns the result.
// Define PCPI_TIMEOUT_EN to abort unclaimed requests after TIMEOUT_CYCLES cycles without pcpi_wait.
module pcpi_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CYC_W          = 8
) (
    input  logic             clk,
    input  logic             resetn,
    pcpi_initiator_if.master bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e           state;
    logic [CYC_W-1:0] cyc_cnt;
    logic [CYC_W-1:0] cyc_next;
    logic             pcpi_valid;
    logic [31:0]      pcpi_insn;
    logic [31:0]      pcpi_rs1;
    logic [31:0]      pcpi_rs2;
    logic             rsp_valid;
    logic [31:0]      rsp_rd;
    logic             rsp_wr;
    logic [CYC_W-1:0] rsp_cycles;

    // Latency counter saturates instead of wrapping.
    always_comb cyc_next = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CYC_W'(1);

`ifdef PCPI_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_next;
    logic            expire;
    logic            rsp_err;

    always_comb begin
        to_next = bus.pcpi_wait ? '0 : to_cnt + TO_W'(1);
        expire  = (to_next == TO_W'(TIMEOUT_CYCLES));
    end
`else
    logic unused_cfg;
    assign unused_cfg = bus.pcpi_wait ^ (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= StIdle;
            cyc_cnt    <= '0;
            pcpi_valid <= 1'b0;
            pcpi_insn  <= '0;
            pcpi_rs1   <= '0;
            pcpi_rs2   <= '0;
            rsp_valid  <= 1'b0;
            rsp_rd     <= '0;
            rsp_wr     <= 1'b0;
            rsp_cycles <= '0;
`ifdef PCPI_TIMEOUT_EN
            to_cnt     <= '0;
            rsp_err    <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        pcpi_insn  <= bus.cmd_insn;
                        pcpi_rs1   <= bus.cmd_rs1;
                        pcpi_rs2   <= bus.cmd_rs2;
                        pcpi_valid <= 1'b1;
                        cyc_cnt    <= '0;
`ifdef PCPI_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                        state      <= StIssue;
                    end
                end
                StIssue: begin
                    cyc_cnt <= cyc_next;
`ifdef PCPI_TIMEOUT_EN
                    to_cnt  <= to_next;
`endif
                    // Ready wins over a simultaneous timeout expiry.
                    if (bus.pcpi_ready) begin
                        rsp_rd     <= bus.pcpi_rd;
                        rsp_wr     <= bus.pcpi_wr;
                        rsp_cycles <= cyc_next;
                        pcpi_valid <= 1'b0;
                        rsp_valid  <= 1'b1;
`ifdef PCPI_TIMEOUT_EN
                        rsp_err    <= 1'b0;
`endif
                        state      <= StResp;
                    end
`ifdef PCPI_TIMEOUT_EN
                    else if (expire) begin
                        rsp_rd     <= '0;
                        rsp_wr     <= 1'b0;
                        rsp_err    <= 1'b1;
                        rsp_cycles <= cyc_next;
                        pcpi_valid <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= StResp;
                    end
`endif
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready  = (state == StIdle);
    assign bus.pcpi_valid = pcpi_valid;
    assign bus.pcpi_insn  = pcpi_insn;
    assign bus.pcpi_rs1   = pcpi_rs1;
    assign bus.pcpi_rs2   = pcpi_rs2;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_rd     = rsp_rd;
    assign bus.rsp_wr     = rsp_wr;
    assign bus.rsp_cycles = rsp_cycles;
`ifdef PCPI_TIMEOUT_EN
    assign bus.rsp_err    = rsp_err;
`else
    assign bus.rsp_err    = 1'b0;
`endif
endmodule

// File: tb/tb_pcpi_initiator.sv
// Scoreboard bench for pcpi_initiator with a configurable-latency PCPI responder.
// Timeout scenarios are only exercised when PCPI_TIMEOUT_EN is defined.
module tb_pcpi_initiator;
    localparam int unsigned CYC_W          = 8;
    localparam int unsigned TIMEOUT_CYCLES = 16;
    localparam int          CYC_MAX        = (1 << CYC_W) - 1;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    pcpi_initiator_if #(.CYC_W(CYC_W)) bus ();

    pcpi_initiator #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CYC_W         (CYC_W)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0]      rd;
        logic             wr;
        logic             err;
        logic [CYC_W-1:0] cycles;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Responder: ready on the resp_lat-th cycle of pcpi_valid (0 = never answers).
    int          resp_lat  = 0;
    bit          resp_mul  = 1'b1;
    logic [31:0] resp_data = '0;
    logic        resp_wr   = 1'b0;
    bit          wait_en   = 1'b0;
    int          vcnt      = 0;
    logic [31:0] mul_res;

    always @(posedge clk) vcnt <= bus.pcpi_valid ? vcnt + 1 : 0;

    assign mul_res        = bus.pcpi_rs1 * {16'h0, bus.pcpi_rs2[15:0]};
    assign bus.pcpi_ready = bus.pcpi_valid && (resp_lat != 0) && (vcnt == resp_lat - 1);
    assign bus.pcpi_rd    = bus.pcpi_ready ? (resp_mul ? mul_res : resp_data) : 32'hBAD0_BAD0;
    assign bus.pcpi_wr    = bus.pcpi_ready ? (resp_mul ? 1'b1 : resp_wr) : 1'b1;
    assign bus.pcpi_wait  = wait_en && bus.pcpi_valid;

    function automatic rsp_t mk_exp(input logic [31:0] rd, input logic wr, input logic err,
                                    input int cycles);
        rsp_t r;
        r.rd     = rd;
        r.wr     = wr;
        r.err    = err;
        r.cycles = CYC_W'((cycles > CYC_MAX) ? CYC_MAX : cycles);
        return r;
    endfunction

    // Issue one command, expect n_issue cycles of pcpi_valid, then hold the response for hold cycles.
    task automatic do_op(input string tag, input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input int lat, input int n_issue,
                         input rsp_t exp, input int hold);
        int          t        = 0;
        int          pv_cnt   = 0;
        int          rdy_hi   = 0;
        int          unstable = 0;
        rsp_t        e;
        logic [31:0] snap_rd;
        logic        snap_wr;
        logic        snap_err;
        logic [31:0] snap_cyc;

        @(negedge clk);
        check({tag, ".cmd_ready_idle"}, 32'(bus.cmd_ready), 32'd1);
        resp_lat      = lat;
        bus.cmd_valid = 1'b1;
        bus.cmd_insn  = insn;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        sb_q.push_back(exp);

        @(negedge clk);
        t             = 1;
        bus.cmd_valid = 1'b0;
        bus.cmd_insn  = ~insn;
        bus.cmd_rs1   = ~rs1;
        bus.cmd_rs2   = ~rs2;
        check({tag, ".pcpi_insn"}, bus.pcpi_insn, insn);
        check({tag, ".pcpi_rs1"}, bus.pcpi_rs1, rs1);
        check({tag, ".pcpi_rs2"}, bus.pcpi_rs2, rs2);

        while (!bus.rsp_valid && t < 2000) begin
            if (bus.pcpi_valid) pv_cnt++;
            if (bus.cmd_ready) rdy_hi++;
            if (bus.pcpi_insn !== insn || bus.pcpi_rs1 !== rs1 || bus.pcpi_rs2 !== rs2)
                unstable++;
            @(negedge clk);
            t++;
        end
        check({tag, ".rsp_valid_seen"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, ".latency"}, 32'(t), 32'(n_issue + 1));
        check({tag, ".pcpi_valid_cycles"}, 32'(pv_cnt), 32'(n_issue));
        check({tag, ".cmd_ready_busy"}, 32'(rdy_hi), 32'd0);
        check({tag, ".operands_stable"}, 32'(unstable), 32'd0);
        check({tag, ".pcpi_valid_at_rsp"}, 32'(bus.pcpi_valid), 32'd0);

        if (sb_q.size() == 0) begin
            check({tag, ".sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".rsp_rd"}, bus.rsp_rd, e.rd);
            check({tag, ".rsp_wr"}, 32'(bus.rsp_wr), 32'(e.wr));
            check({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(e.err));
            check({tag, ".rsp_cycles"}, 32'(bus.rsp_cycles), 32'(e.cycles));
        end

        snap_rd  = bus.rsp_rd;
        snap_wr  = bus.rsp_wr;
        snap_err = bus.rsp_err;
        snap_cyc = 32'(bus.rsp_cycles);
        unstable = 0;
        rdy_hi   = 0;
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid = (i == hold / 2);
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_rd !== snap_rd || bus.rsp_wr !== snap_wr ||
                bus.rsp_err !== snap_err || 32'(bus.rsp_cycles) !== snap_cyc || bus.pcpi_valid)
                unstable++;
            if (bus.cmd_ready) rdy_hi++;
        end
        bus.cmd_valid = 1'b0;
        if (hold > 0) begin
            check({tag, ".rsp_hold_stable"}, 32'(unstable), 32'd0);
            check({tag, ".cmd_ready_resp"}, 32'(rdy_hi), 32'd0);
        end

        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, ".rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ".cmd_ready_back"}, 32'(bus.cmd_ready), 32'd1);
        check({tag, ".no_stray_issue"}, 32'(bus.pcpi_valid), 32'd0);
    endtask

    initial begin
        resetn        = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_insn  = '0;
        bus.cmd_rs1   = '0;
        bus.cmd_rs2   = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset.pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
        check("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset.rsp_wr", 32'(bus.rsp_wr), 32'd0);
        check("reset.rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset.pcpi_insn", bus.pcpi_insn, 32'd0);
        check("reset.pcpi_rs1", bus.pcpi_rs1, 32'd0);
        check("reset.pcpi_rs2", bus.pcpi_rs2, 32'd0);
        check("reset.rsp_rd", bus.rsp_rd, 32'd0);
        check("reset.rsp_cycles", 32'(bus.rsp_cycles), 32'd0);
        resetn = 1'b1;

        resp_mul = 1'b1;
        do_op("mul", 32'h0200_0033, 32'h1234_5678, 32'h0001_0003, 2, 2,
              mk_exp(32'h369D_0368, 1'b1, 1'b0, 2), 0);

        resp_mul  = 1'b0;
        resp_data = 32'hDEAD_BEEF;
        resp_wr   = 1'b0;
        do_op("slow", 32'h0000_000B, 32'hA5A5_0001, 32'h5A5A_0002, 6, 6,
              mk_exp(32'hDEAD_BEEF, 1'b0, 1'b0, 6), 7);

        resp_mul = 1'b1;
        wait_en  = 1'b1;
        do_op("sat", 32'h0200_0033, 32'd7, 32'd5, 300, 300,
              mk_exp(32'd35, 1'b1, 1'b0, 300), 0);
        wait_en = 1'b0;

`ifdef PCPI_TIMEOUT_EN
        do_op("timeout", 32'hFFFF_FFFF, 32'h1, 32'h2, 0, TIMEOUT_CYCLES,
              mk_exp(32'd0, 1'b0, 1'b1, TIMEOUT_CYCLES), 3);

        wait_en = 1'b1;
        do_op("wait100", 32'h0200_0033, 32'd9, 32'd9, 101, 101,
              mk_exp(32'd81, 1'b1, 1'b0, 101), 0);
        wait_en = 1'b0;

        resp_mul  = 1'b0;
        resp_data = 32'hCAFE_F00D;
        resp_wr   = 1'b1;
        do_op("expiry_edge", 32'h0000_1234, 32'h3, 32'h4, TIMEOUT_CYCLES, TIMEOUT_CYCLES,
              mk_exp(32'hCAFE_F00D, 1'b1, 1'b0, TIMEOUT_CYCLES), 0);
        resp_mul = 1'b1;
`endif

        // Reset while a request is outstanding; nothing is pushed since it is discarded.
        @(negedge clk);
        resp_lat      = 10;
        bus.cmd_valid = 1'b1;
        bus.cmd_insn  = 32'h0200_0033;
        bus.cmd_rs1   = 32'd100;
        bus.cmd_rs2   = 32'd100;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid.in_issue", 32'(bus.pcpi_valid), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("rst_mid.pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
        check("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_mid.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        check("rst_mid.stays_idle", 32'(bus.rsp_valid | bus.pcpi_valid), 32'd0);

        do_op("mul_after_rst", 32'h0200_0033, 32'd3, 32'd4, 2, 2,
              mk_exp(32'd12, 1'b1, 1'b0, 2), 0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
